// File: rtl/seq_branch_comparator.sv
// Multi-cycle RV32I branch comparator. It scans the operands one CHUNK at a time,
// starting with the most significant chunk, and stops at the first chunk that differs.
//
// state | meaning
// IDLE  | ready for a request; in_ready is high
// SCAN  | comparing the chunk at idx_q; stops early at the first differing chunk
// DONE  | result is held; out_valid is high until out_ready
module seq_branch_comparator #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             result,
    output logic             eq,
    output logic             lt,
    output logic             err
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = '0;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [2:0] OP_BEQ  = 3'b000;
    localparam logic [2:0] OP_BNE  = 3'b001;
    localparam logic [2:0] OP_BLT  = 3'b100;
    localparam logic [2:0] OP_BGE  = 3'b101;
    localparam logic [2:0] OP_BLTU = 3'b110;
    localparam logic [2:0] OP_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             eq_q, lt_q, res_q, err_q;

    logic             load;
    logic             latch;
    logic             eq_d, lt_d, res_d, err_d;
    logic             op_signed;
    logic [WIDTH-1:0] sign_flip;
    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic             chunk_eq, chunk_lt;

    // Flipping both MSBs maps two's-complement order onto unsigned order,
    // so the chunk datapath only ever needs an unsigned compare.
    assign op_signed = (op[2:1] == 2'b10);
    assign sign_flip = op_signed ? MSB_MASK : '0;

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    assign chunk_eq = (a_chunk == b_chunk);
    assign chunk_lt = (a_chunk < b_chunk);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        latch   = 1'b0;
        eq_d    = eq_q;
        lt_d    = lt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (!chunk_eq) begin
                    latch   = 1'b1;
                    eq_d    = 1'b0;
                    lt_d    = chunk_lt;
                    state_d = DONE;
                end else if (idx_q == IDX_ZERO) begin
                    latch   = 1'b1;
                    eq_d    = 1'b1;
                    lt_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDX_ONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reserved funct3 values still run the full scan; only the outcome is masked.
    always_comb begin
        res_d = 1'b0;
        err_d = 1'b0;
        case (op_q)
            OP_BEQ:           res_d = eq_d;
            OP_BNE:           res_d = !eq_d;
            OP_BLT, OP_BLTU:  res_d = lt_d;
            OP_BGE, OP_BGEU:  res_d = !lt_d;
            default:          err_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            idx_q <= '0;
        end else if (load) begin
            a_q   <= a ^ sign_flip;
            b_q   <= b ^ sign_flip;
            op_q  <= op;
            idx_q <= IDX_LAST;
        end else begin
            idx_q <= idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eq_q  <= 1'b0;
            lt_q  <= 1'b0;
            res_q <= 1'b0;
            err_q <= 1'b0;
        end else if (latch) begin
            eq_q  <= eq_d;
            lt_q  <= lt_d;
            res_q <= res_d;
            err_q <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    assign eq        = eq_q;
    assign lt        = lt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_seq_branch_comparator.sv
// Directed and random checks of seq_branch_comparator (WIDTH=32, CHUNK=8). A reference
// model fills a scoreboard when each request is driven; results are compared when out_valid rises.
module tb_seq_branch_comparator;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic             result;
    logic             eq;
    logic             lt;
    logic             err;

    typedef struct {
        logic eq;
        logic lt;
        logic result;
        logic err;
        int   lat;
    } exp_t;

    exp_t sb[$];
    exp_t last_e;
    int   n_assert;
    int   n_fail;

    seq_branch_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .eq        (eq),
        .lt        (lt),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb, input logic [2:0] mop);
        exp_t e;
        logic [31:0] ta;
        logic [31:0] tb;
        e.eq  = (ma == mb);
        e.lt  = (mop == 3'b100 || mop == 3'b101) ? ($signed(ma) < $signed(mb)) : (ma < mb);
        e.err = (mop == 3'b010 || mop == 3'b011);
        case (mop)
            3'b000:         e.result = e.eq;
            3'b001:         e.result = !e.eq;
            3'b100, 3'b110: e.result = e.lt;
            3'b101, 3'b111: e.result = !e.lt;
            default:        e.result = 1'b0;
        endcase
        e.lat = 0;
        ta = ma;
        tb = mb;
        for (int j = NCHUNK - 1; j >= 0; j--) begin
            e.lat++;
            if (ta[j*CHUNK +: CHUNK] != tb[j*CHUNK +: CHUNK]) break;
        end
        return e;
    endfunction

    // Returns one time unit after the accepting edge, with inputs scrambled.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] iop);
        @(negedge clk);
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        op       = iop;
        check("in_ready_before_accept", in_ready, 1'b1);
        @(posedge clk);
        sb.push_back(model(ia, ib, iop));
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        op       = 3'($urandom_range(0, 7));
    endtask

    task automatic await_result(input string tag);
        int cycles;
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check({tag, "_out_valid"}, out_valid, 1'b1);
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_nonempty"}, 32'(sb.size()), 32'd1);
        end else begin
            last_e = sb.pop_front();
            check({tag, "_latency"}, 32'(cycles), 32'(last_e.lat));
            check({tag, "_result"}, result, last_e.result);
            check({tag, "_eq"}, eq, last_e.eq);
            check({tag, "_lt"}, lt, last_e.lt);
            check({tag, "_err"}, err, last_e.err);
            check({tag, "_in_ready_busy"}, in_ready, 1'b0);
        end
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_in_ready_after"}, in_ready, 1'b1);
        check({tag, "_out_valid_after"}, out_valid, 1'b0);
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 1'b0);
        check("rst_eq", eq, 1'b0);
        check("rst_lt", lt, 1'b0);
        check("rst_err", err, 1'b0);
        rst_n = 1'b1;

        issue(32'h0000_0005, 32'h0000_0005, 3'b000);
        await_result("beq_equal");
        check("beq_equal_lat4", 32'(last_e.lat), 32'd4);
        check("beq_equal_res1", result, 1'b1);
        release_result("beq_equal");

        issue(32'h8000_0000, 32'h0000_0001, 3'b100);
        await_result("blt_neg");
        check("blt_neg_res1", result, 1'b1);
        check("blt_neg_lt1", lt, 1'b1);
        release_result("blt_neg");

        issue(32'h8000_0000, 32'h0000_0001, 3'b110);
        await_result("bltu_big");
        check("bltu_big_res0", result, 1'b0);
        check("bltu_big_lt0", lt, 1'b0);
        release_result("bltu_big");

        issue(32'h1234_5600, 32'h1234_5601, 3'b111);
        await_result("bgeu_lsb");
        check("bgeu_lsb_res0", result, 1'b0);
        check("bgeu_lsb_lt1", lt, 1'b1);
        release_result("bgeu_lsb");

        issue(32'h00FF_0000, 32'h00FE_0000, 3'b001);
        await_result("stall");
        for (int s = 0; s < 3; s++) begin
            @(posedge clk);
            #1;
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_result", result, last_e.result);
            check("stall_eq", eq, last_e.eq);
            check("stall_lt", lt, last_e.lt);
            check("stall_in_ready", in_ready, 1'b0);
        end
        release_result("stall");

        issue(32'h0000_0005, 32'h0000_0005, 3'b000);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midscan_rst_out_valid", out_valid, 1'b0);
        check("midscan_rst_in_ready", in_ready, 1'b1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 6; s++) begin
            @(posedge clk);
            #1;
            check("post_rst_no_output", out_valid, 1'b0);
        end

        issue(32'h0000_0000, 32'h0000_0000, 3'b010);
        await_result("reserved");
        check("reserved_err1", err, 1'b1);
        check("reserved_res0", result, 1'b0);
        release_result("reserved");
        issue(32'hFFFF_FFFE, 32'h0000_0003, 3'b101);
        await_result("b2b_legal");
        check("b2b_legal_err0", err, 1'b0);
        release_result("b2b_legal");

        for (int n = 0; n < 30; n++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            int          k;
            ra = $urandom;
            k  = $urandom_range(0, 4);
            if (k == 4) rb = ra;
            else rb = ra ^ (32'($urandom_range(1, 255)) << (8 * k));
            if ($urandom_range(0, 3) == 0) rb = $urandom;
            issue(ra, rb, 3'($urandom_range(0, 7)));
            await_result("random");
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            check("random_hold_result", result, last_e.result);
            release_result("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
